regfile_onehot: RTL
===================

// Module: regfile_onehot
// PURPOSE
//   32-entry x DATA_WIDTH register file for the processor writeback/operand-fetch path.
//   The write port takes a 5-bit destination index, decodes it to a 32-bit one-hot
//   write-enable vector, and gates that vector with ctrl_writeEnable to clock one row.
//   Two combinational read ports feed the decode/execute stage. Register 0 always reads zero.
//   The optional write-to-read bypass removes the same-cycle writeback/read hazard.
// PARAMETERS
//   DATA_WIDTH  32  width of each register and of all data ports
//   BYPASS      1   1 = same-cycle write data forwarded to matching read port; 0 = no forwarding
// PORTS
//   clock             in   1           rising-edge clock for all state
//   ctrl_reset        in   1           synchronous, active-high reset
//   ctrl_writeEnable  in   1           write strobe, sampled at rising edge
//   ctrl_writeReg     in   5           destination register index
//   data_writeReg     in   DATA_WIDTH  write data
//   ctrl_readRegA     in   5           read port A index
//   ctrl_readRegB     in   5           read port B index
//   data_readRegA     out  DATA_WIDTH  read port A data (combinational)
//   data_readRegB     out  DATA_WIDTH  read port B data (combinational)
// BEHAVIOUR
//   - Storage: regs r1..r31 are DATA_WIDTH flops. r0 is not stored and is constant 0.
//   - Write decode
//     - we_vec[i] = ctrl_writeEnable & (ctrl_writeReg == i), i = 1..31.
//     - we_vec[0] is forced to 0.
//     - At most one bit is set per cycle.
//   - Rising edge, priority order
//     1. ctrl_reset=1: every r1..r31 <= 0. Any write in that cycle is dropped.
//     2. else if we_vec[i]=1: r_i <= data_writeReg.
//     3. else: all rows hold.
//   - Write latency: data written at edge N is visible on the read ports right after
//     edge N (no bypass needed).
//   - Reads: data_readRegX = 0 if ctrl_readRegX == 0, otherwise the stored r value.
//     Purely combinational, zero-cycle latency.
//   - Bypass (BYPASS=1): if ctrl_writeEnable=1, ctrl_reset=0, ctrl_writeReg != 0 and
//     ctrl_writeReg == ctrl_readRegX, then data_readRegX = data_writeReg in that cycle.
//     - Applies to A and B independently. Both ports may bypass at once.
//     - Suppressed while ctrl_reset=1 and for index 0.
//   - BYPASS=0: reads return the pre-edge stored value during a colliding write.
//   - Reset values
//     - No output flops. After any reset edge, both read ports return 0 for every index
//       until the next write.
//     - Reset applied mid-operation (between writes) clears all prior contents at that edge.
//   - Write to index 0: accepted on the bus, no state change, no bypass. r0 reads stay 0.
//   - Write data is stored unmodified at full DATA_WIDTH. No sign/zero extension inside.
//   - No X-propagation from unwritten rows: every row is defined after the first reset.
// TESTING
//   1. Reset, then read all 32 indices on A and B -> every read returns 0.
//   2. Write r5=0xDEADBEEF, next cycle read A=5, B=5 -> both 0xDEADBEEF.
//      All other indices still read 0.
//   3. Write r0=0xFFFFFFFF, then read A=0 -> 0x00000000. With BYPASS=1, read A=0 during
//      the write cycle -> 0x00000000.
//   4. BYPASS=1: same cycle write r7=0x12345678 with read A=7, B=8 ->
//      A=0x12345678 combinationally, B=old r8. With BYPASS=0 -> A=old r7.
//   5. Write r31=0xA5A5A5A5 and assert ctrl_reset on the same edge -> r31 reads 0 after
//      the edge; bypass output during that cycle is the stored value, not 0xA5A5A5A5.
//   6. Walk writes r1..r31 with value i*0x01010101, then read back all pairs (i, 32-i)
//      -> exact values, no aliasing between rows.

Source files
------------

// File: rtl/regfile_onehot.sv
// 32-entry register file with one-hot write decode, two combinational read ports
// and optional same-cycle write-to-read forwarding. Register 0 is hard-wired to zero.
module regfile_onehot #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [4:0]            ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [4:0]            ctrl_readRegA,
  input  logic [4:0]            ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB
);

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned IDX_W    = 5;

  // Row 0 has no storage and no enable bit.
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [NUM_REGS-1:1]   we_vec;
  logic [DATA_WIDTH-1:0] stored_a;
  logic [DATA_WIDTH-1:0] stored_b;
  logic                  byp_a;
  logic                  byp_b;

  always_comb begin
    we_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      we_vec[i] = ctrl_writeEnable && (ctrl_writeReg == IDX_W'(i));
    end
  end

  // Reset has priority over the write strobe.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (we_vec[i]) begin
          regs_q[i] <= data_writeReg;
        end
      end
    end
  end

  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ctrl_readRegA == IDX_W'(i)) begin
        stored_a = regs_q[i];
      end
      if (ctrl_readRegB == IDX_W'(i)) begin
        stored_b = regs_q[i];
      end
    end
  end

  // Forward only a write that will actually land this edge.
  always_comb begin
    byp_a = BYPASS && ctrl_writeEnable && !ctrl_reset &&
            (ctrl_writeReg != '0) && (ctrl_writeReg == ctrl_readRegA);
    byp_b = BYPASS && ctrl_writeEnable && !ctrl_reset &&
            (ctrl_writeReg != '0) && (ctrl_writeReg == ctrl_readRegB);
  end

  assign data_readRegA = byp_a ? data_writeReg : stored_a;
  assign data_readRegB = byp_b ? data_writeReg : stored_b;

endmodule
